// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2**ADDR_LEN words with registered read data and full/empty flags.
// Define FIFO_STATUS_EN to add fill_count, wr_overflow and rd_underflow outputs.
module sync_fifo #(
    parameter int DATA_LEN = 8,
    parameter int ADDR_LEN = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_en,
    output logic [DATA_LEN-1:0] rd_data,
    output logic                wr_full,
    output logic                rd_empty
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_LEN:0]   fill_count,
    output logic                wr_overflow,
    output logic                rd_underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_LEN;

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [ADDR_LEN:0]   wr_ptr;
    logic [ADDR_LEN:0]   rd_ptr;
    logic                wr_acc;
    logic                rd_acc;

    // Extra MSB distinguishes full (lap ahead) from empty (same lap).
    assign rd_empty = (wr_ptr == rd_ptr);
    assign wr_full  = (wr_ptr[ADDR_LEN] != rd_ptr[ADDR_LEN]) &&
                      (wr_ptr[ADDR_LEN-1:0] == rd_ptr[ADDR_LEN-1:0]);

    assign wr_acc = wr_en && !wr_full;
    assign rd_acc = rd_en && !rd_empty;

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr[ADDR_LEN-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[ADDR_LEN-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef FIFO_STATUS_EN
    assign fill_count = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            wr_overflow  <= wr_en && wr_full;
            rd_underflow <= rd_en && rd_empty;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based model predicts read data and flags,
// a negedge monitor compares them against the DUT every cycle.
module tb_sync_fifo;

    localparam int DATA_LEN = 8;
    localparam int ADDR_LEN = 3;
    localparam int DEPTH    = 1 << ADDR_LEN;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                wr_en = 1'b0;
    logic [DATA_LEN-1:0] wr_data = '0;
    logic                rd_en = 1'b0;
    logic [DATA_LEN-1:0] rd_data;
    logic                wr_full;
    logic                rd_empty;
`ifdef FIFO_STATUS_EN
    logic [ADDR_LEN:0]   fill_count;
    logic                wr_overflow;
    logic                rd_underflow;
`endif

    sync_fifo #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .wr_full(wr_full), .rd_empty(rd_empty)
`ifdef FIFO_STATUS_EN
        , .fill_count(fill_count), .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a plain queue, expected rd_data updates as a second queue.
    logic [DATA_LEN-1:0] model_q[$];
    logic [DATA_LEN-1:0] exp_q[$];
    logic [DATA_LEN-1:0] hold_val = '0;
    bit                  armed = 1'b0;
    bit                  exp_ovf = 1'b0;
    bit                  exp_udf = 1'b0;
    int                  ovf_pulses = 0;

    always @(posedge clk) begin
        int n;
        n = model_q.size();
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            exp_q.push_back('0);
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            exp_ovf = wr_en && (n == DEPTH);
            exp_udf = rd_en && (n == 0);
            if (exp_ovf) ovf_pulses++;
            if (rd_en && n != 0)
                exp_q.push_back(model_q.pop_front());
            if (wr_en && n != DEPTH)
                model_q.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (exp_q.size() != 0)
                hold_val = exp_q.pop_front();
            check("rd_data",  32'(rd_data),  32'(hold_val));
            check("rd_empty", 32'(rd_empty), 32'(model_q.size() == 0));
            check("wr_full",  32'(wr_full),  32'(model_q.size() == DEPTH));
`ifdef FIFO_STATUS_EN
            check("fill_count",   32'(fill_count),   32'(model_q.size()));
            check("wr_overflow",  32'(wr_overflow),  32'(exp_ovf));
            check("rd_underflow", 32'(rd_underflow), 32'(exp_udf));
`endif
        end
    end

    task automatic drive(input bit r, input bit w, input logic [DATA_LEN-1:0] d, input bit rd);
        @(posedge clk);
        #1;
        rst = r; wr_en = w; wr_data = d; rd_en = rd;
    endtask

    initial begin
        int ovf_start;
        // Reset with both requests asserted: reset wins.
        drive(1'b1, 1'b1, 8'hAA, 1'b1);
        drive(1'b1, 1'b1, 8'hBB, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Alternating stream with a continuous reader.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 8'(i * 8'h11), 1'b1);
            drive(1'b0, 1'b0, 8'h00, 1'b1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill past capacity; the last four writes are dropped.
        ovf_start = ovf_pulses;
        for (int i = 1; i <= 12; i++)
            drive(1'b0, 1'b1, 8'(i), 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("overflow_count", 32'(ovf_pulses - ovf_start), 32'd4);

        // Drain past empty; rd_data holds the last word.
        for (int i = 0; i < 11; i++)
            drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("drain_hold", 32'(rd_data), 32'h08);

        // Refill, then one simultaneous read/write while full.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("full_simul_rd", 32'(rd_data), 32'h40);
        check("full_simul_cnt", 32'(model_q.size()), 32'd7);
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b0, 8'h00, 1'b1);

        // 20 words through with 3 in flight (pointers wrap), then reset mid-run.
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b1, 8'(8'hA0 + i), i >= 3);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_rst_empty", 32'(rd_empty), 32'd1);
        check("post_rst_data",  32'(rd_data),  32'h00);

        // Random traffic, with occasional resets.
        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
